branch_resolve_ctrl: RTL and testbench

- Branch prediction and misprediction-recovery controller for the in-order RISC-V pipeline.
- Holds a bimodal branch history table (BHT) of 2-bit saturating counters. IF reads it to get a taken/not-taken prediction.
- Consumes the EX-stage branch outcome (taken flag from the branch condition logic) and compares it with the prediction carried down the pipe.
- On mismatch, sequences the front-end flush and PC redirect, and keeps branch/mispredict statistics.

---
 rtl/branch_resolve_ctrl.sv | 123 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// Bimodal branch predictor with EX-stage resolution, mispredict flush/redirect
// sequencing and saturating branch statistics.
module branch_resolve_ctrl #(
    parameter int IDX_BITS     = 6,
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic            ex_branch,
    input  logic            ex_taken,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int CNT_W   = 3;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 flush_d, busy_d, redirect_valid_d;
    logic [XLEN-1:0]      redirect_pc_d;
    logic [1:0]           bht [ENTRIES];
    logic [IDX_BITS-1:0]  if_idx, ex_idx;
    logic                 resolve, mispredict;
    logic                 unused_pc_bits;

    assign if_idx         = if_pc[IDX_BITS+1:2];
    assign ex_idx         = ex_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0]};

    // Plain read of the array: an update in this cycle is seen only from the next one.
    assign pred_taken = bht[if_idx][1];

    assign resolve    = ex_valid & ~ex_stall & ex_branch & (state_q == IDLE);
    assign mispredict = resolve & (ex_taken != ex_pred_taken);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        state_d          = state_q;
        cnt_d            = cnt_q;
        flush_d          = flush;
        busy_d           = busy;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc;
        unique case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d          = FLUSH;
                    cnt_d            = CNT_W'(FLUSH_CYCLES - 1);
                    flush_d          = 1'b1;
                    busy_d           = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = ex_taken ? ex_target : ex_pc + XLEN'(4);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            flush          <= 1'b0;
            busy           <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            br_count       <= '0;
            mispred_count  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            flush          <= flush_d;
            busy           <= busy_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            if (resolve && br_count != 32'hFFFF_FFFF)
                br_count <= br_count + 32'd1;
            if (mispredict && mispred_count != 32'hFFFF_FFFF)
                mispred_count <= mispred_count + 32'd1;
        end
    end

    // NOTE: the table is a flop array, not RAM, because reset must return every
    // entry to weakly-not-taken; a RAM macro could not be cleared in one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
        end else if (resolve) begin
            if (ex_taken && bht[ex_idx] != 2'b11)
                bht[ex_idx] <= bht[ex_idx] + 2'b01;
            else if (!ex_taken && bht[ex_idx] != 2'b00)
                bht[ex_idx] <= bht[ex_idx] - 2'b01;
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: prediction, flush/redirect timing,
// stall and wrong-path filtering, reset during flush, and counter saturation.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid, ex_stall, ex_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target;
    logic        flush, redirect_valid, busy;
    logic [31:0] redirect_pc, br_count, mispred_count;

    int n_asserts = 0;
    int n_fails   = 0;

    branch_resolve_ctrl #(.IDX_BITS(6), .XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_branch(ex_branch),
        .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
        .ex_target(ex_target), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy), .br_count(br_count),
        .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic pt);
        ex_valid      = 1'b1;
        ex_branch     = 1'b1;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_taken      = tk;
        ex_pred_taken = pt;
    endtask

    task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(tag, {31'd0, pred_taken}, {31'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; if_pc = '0; ex_valid = 0; ex_stall = 0; ex_branch = 0;
        ex_taken = 0; ex_pred_taken = 0; ex_pc = '0; ex_target = '0;
        step(); step();
        rst_n = 1'b1;

        // 1: reset state and cold table
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rv", {31'd0, redirect_valid}, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_br", br_count, 32'd0);
        check("rst_mp", mispred_count, 32'd0);
        for (int i = 0; i < 64; i++) pred_at($sformatf("cold_pred_%0d", i), 32'(i * 4), 1'b0);

        // 2: taken mispredict at 0x40
        present(32'h40, 32'h80, 1'b1, 1'b0);
        step();
        ex_valid = 1'b0;
        check("mp1_rv", {31'd0, redirect_valid}, 32'd1);
        check("mp1_rpc", redirect_pc, 32'h80);
        check("mp1_flush_c1", {31'd0, flush}, 32'd1);
        check("mp1_busy", {31'd0, busy}, 32'd1);
        check("mp1_mpcnt", mispred_count, 32'd1);
        check("mp1_brcnt", br_count, 32'd1);
        step();
        check("mp1_rv_drop", {31'd0, redirect_valid}, 32'd0);
        check("mp1_flush_c2", {31'd0, flush}, 32'd1);
        check("mp1_rpc_hold", redirect_pc, 32'h80);
        step();
        check("mp1_flush_end", {31'd0, flush}, 32'd0);
        check("mp1_busy_end", {31'd0, busy}, 32'd0);
        pred_at("mp1_pred40", 32'h40, 1'b1);

        // 3: saturate at 11 with correct predictions, then a not-taken mispredict
        for (int i = 0; i < 3; i++) begin
            present(32'h40, 32'h80, 1'b1, 1'b1);
            step();
            check($sformatf("ok_flush_%0d", i), {31'd0, flush}, 32'd0);
            check($sformatf("ok_rv_%0d", i), {31'd0, redirect_valid}, 32'd0);
        end
        ex_valid = 1'b0;
        check("ok_brcnt", br_count, 32'd4);
        check("ok_mpcnt", mispred_count, 32'd1);
        present(32'h40, 32'h80, 1'b0, 1'b1);
        step();
        ex_valid = 1'b0;
        check("mp2_rv", {31'd0, redirect_valid}, 32'd1);
        check("mp2_rpc", redirect_pc, 32'h44);
        check("mp2_mpcnt", mispred_count, 32'd2);
        pred_at("mp2_pred40", 32'h40, 1'b1);
        step(); step();
        check("mp2_flush_end", {31'd0, flush}, 32'd0);
        present(32'h40, 32'h80, 1'b0, 1'b1);
        step();
        ex_valid = 1'b0;
        check("mp3_rpc", redirect_pc, 32'h44);
        pred_at("mp3_pred40", 32'h40, 1'b0);
        step(); step();
        check("mp3_flush_end", {31'd0, flush}, 32'd0);
        check("mp3_brcnt", br_count, 32'd6);

        // 4: stalled branch, then a wrong-path branch during flush
        present(32'h80, 32'h100, 1'b1, 1'b0);
        ex_stall = 1'b1;
        step(); step(); step();
        check("stall_brcnt", br_count, 32'd6);
        check("stall_flush", {31'd0, flush}, 32'd0);
        pred_at("stall_pred80", 32'h80, 1'b0);
        ex_stall = 1'b0;
        step();
        check("rel_brcnt", br_count, 32'd7);
        check("rel_mpcnt", mispred_count, 32'd4);
        check("rel_rpc", redirect_pc, 32'h100);
        present(32'hC0, 32'h200, 1'b1, 1'b0);
        step();
        check("wp_flush_c2", {31'd0, flush}, 32'd1);
        check("wp_rv", {31'd0, redirect_valid}, 32'd0);
        step();
        ex_valid = 1'b0;
        check("wp_flush_end", {31'd0, flush}, 32'd0);
        check("wp_brcnt", br_count, 32'd7);
        check("wp_mpcnt", mispred_count, 32'd4);
        check("wp_rpc", redirect_pc, 32'h100);
        pred_at("wp_predC0", 32'hC0, 1'b0);
        pred_at("rel_pred80", 32'h80, 1'b1);

        // 5: reset in the second flush cycle
        present(32'h100, 32'h300, 1'b1, 1'b0);
        step();
        ex_valid = 1'b0;
        step();
        check("rstf_flush_pre", {31'd0, flush}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rstf_flush", {31'd0, flush}, 32'd0);
        check("rstf_busy", {31'd0, busy}, 32'd0);
        check("rstf_br", br_count, 32'd0);
        check("rstf_mp", mispred_count, 32'd0);
        check("rstf_rpc", redirect_pc, 32'd0);
        pred_at("rstf_pred80", 32'h80, 1'b0);
        pred_at("rstf_pred100", 32'h100, 1'b0);

        // 6: counter saturation and PC wrap on ex_pc + 4
        force dut.br_count = 32'hFFFF_FFFE;
        #1;
        release dut.br_count;
        for (int i = 0; i < 3; i++) begin
            present(32'h10, 32'h20, 1'b0, 1'b0);
            step();
            check($sformatf("sat_br_%0d", i), br_count, 32'hFFFF_FFFF);
        end
        present(32'hFFFF_FFFC, 32'h20, 1'b0, 1'b1);
        step();
        ex_valid = 1'b0;
        check("wrap_rv", {31'd0, redirect_valid}, 32'd1);
        check("wrap_rpc", redirect_pc, 32'h0);
        check("wrap_br", br_count, 32'hFFFF_FFFF);
        check("wrap_mp", mispred_count, 32'd1);
        step(); step();
        check("wrap_flush_end", {31'd0, flush}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
